// File: rtl/m_wb_arb_pkg.sv
// m_wb_arb_pkg: constants shared by the writeback arbiter and its FIFO.
//   XLEN     - register-file write-port data width
//   REG_ZERO - hard-wired zero register index; writes to it are discarded
//   NREGS    - number of architectural registers tracked by the scoreboard
package m_wb_arb_pkg;
    localparam int         XLEN     = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         NREGS    = 32;
endpackage

// File: rtl/m_wb_arb_fifo.sv
// m_wb_fifo: DEPTH-entry synchronous FIFO holding pending long-latency
// results ({wa,wd}) until a register-file write slot is free.
//   w_clk/w_rst_n    clock, async active-low reset (empties the FIFO)
//   i_push, i_din    enqueue when i_push (caller guarantees not full)
//   i_pop            dequeue head (caller guarantees not empty)
//   o_head           current head entry
//   o_cnt            occupancy, o_full / o_empty status flags
module m_wb_fifo
    import m_wb_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 5 + XLEN
) (
    input  logic                     w_clk,
    input  logic                     w_rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_cnt,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop)  r_rp <= r_rp + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Data storage needs no reset; r_cnt gates visibility.
    always_ff @(posedge w_clk) begin
        if (i_push) r_mem[r_wp] <= i_din;
    end

    assign o_head  = r_mem[r_rp];
    assign o_cnt   = r_cnt;
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
endmodule

// File: rtl/m_wb_arb.sv
// m_wb_arb: writeback arbiter in front of the register file's single write
// port. In-order pipeline writebacks have priority; out-of-order long-latency
// results bypass straight to the port when it is idle, otherwise wait in a
// small FIFO. A per-register busy scoreboard tracks issued long ops.
//   w_clk, w_rst_n                 clock, async active-low reset
//   w_p_we/w_p_wa/w_p_wd           pipeline writeback
//   w_l_valid/w_l_ready/w_l_wa/wd  long-latency result handshake
//   w_iss_v/w_iss_rd               long op issue (sets busy)
//   w_we/w_wa/w_wd                 register-file write port
//   w_busy                         pending long destinations
//   w_stall                        FIFO full, pipeline must freeze writeback
//   w_cnt                          FIFO occupancy
module m_wb_arb
    import m_wb_arb_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int DEPTH  = 2
) (
    input  logic                   w_clk,
    input  logic                   w_rst_n,
    input  logic                   w_p_we,
    input  logic [4:0]             w_p_wa,
    input  logic [XLEN_P-1:0]      w_p_wd,
    input  logic                   w_l_valid,
    output logic                   w_l_ready,
    input  logic [4:0]             w_l_wa,
    input  logic [XLEN_P-1:0]      w_l_wd,
    input  logic                   w_iss_v,
    input  logic [4:0]             w_iss_rd,
    output logic                   w_we,
    output logic [4:0]             w_wa,
    output logic [XLEN_P-1:0]      w_wd,
    output logic [NREGS-1:0]       w_busy,
    output logic                   w_stall,
    output logic [$clog2(DEPTH):0] w_cnt
);
    localparam int W = 5 + XLEN_P;

    logic              w_p_req, w_l_req, w_hs;
    logic              w_full, w_empty;
    logic              w_push, w_pop, w_byp, w_we_raw;
    logic [W-1:0]      w_head;
    logic [4:0]        w_head_wa;
    logic [XLEN_P-1:0] w_head_wd;
    logic [NREGS-1:0]  w_set, w_clr;
    logic [NREGS-1:0]  r_busy;

    assign w_p_req   = w_p_we    && (w_p_wa != REG_ZERO);
    assign w_l_req   = w_l_valid && (w_l_wa != REG_ZERO);
    // Ready/stall depend only on FIFO state, never on the pipeline inputs.
    assign w_l_ready = !w_full;
    assign w_stall   = w_full;
    assign w_hs      = w_l_valid && w_l_ready;
    assign {w_head_wa, w_head_wd} = w_head;

    always_comb begin
        w_we_raw = 1'b0;
        w_wa     = REG_ZERO;
        w_wd     = '0;
        w_pop    = 1'b0;
        w_byp    = 1'b0;
        if (w_full) begin
            w_we_raw = 1'b1;
            w_wa     = w_head_wa;
            w_wd     = w_head_wd;
            w_pop    = 1'b1;
        end else if (w_p_req) begin
            w_we_raw = 1'b1;
            w_wa     = w_p_wa;
            w_wd     = w_p_wd;
        end else if (!w_empty) begin
            w_we_raw = 1'b1;
            w_wa     = w_head_wa;
            w_wd     = w_head_wd;
            w_pop    = 1'b1;
        end else if (w_l_req && w_l_ready) begin
            w_we_raw = 1'b1;
            w_wa     = w_l_wa;
            w_wd     = w_l_wd;
            w_byp    = 1'b1;
        end
    end

    // x0 long results complete the handshake but are never queued, so the
    // FIFO head is always a real destination.
    assign w_push = w_hs && w_l_req && !w_byp;
    // Reset must kill the write strobe immediately, even mid-cycle.
    assign w_we   = w_we_raw && w_rst_n;

    m_wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .i_push  (w_push),
        .i_din   ({w_l_wa, w_l_wd}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_cnt   (w_cnt),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_set = (w_iss_v && (w_iss_rd != REG_ZERO)) ? (NREGS'(1) << w_iss_rd) : '0;
    assign w_clr = (w_pop || w_byp) ? (NREGS'(1) << w_wa) : '0;

    // Set after clear so a same-cycle reissue of the retiring register wins.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) r_busy <= '0;
        else          r_busy <= ((r_busy & ~w_clr) | w_set) & ~NREGS'(1);
    end

    assign w_busy = r_busy;
endmodule
